// File: rtl/ram32b_arb_pkg.sv
// Shared types and constants for the 32 x 8 RAM arbiter: FSM encoding,
// default widths and the RAM wr_rd encoding.
package ram32b_arb_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_DATA_W = 8;

    localparam logic OP_WR = 1'b1;
    localparam logic OP_RD = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CMD    = 2'd1,
        RDWAIT = 2'd2
    } state_e;

    // Client index: 0 = client 0, 1 = client 1
    typedef logic client_t;

endpackage

// File: rtl/ram32b_arbiter_rr_arb2.sv
// Combinational two-way winner select. RAMARB_FIXED_PRIO_EN selects a fixed
// priority (client 0 wins ties) instead of round robin on the last pointer.
module rr_arb2
    import ram32b_arb_pkg::*;
(
    input  logic    req0,
    input  logic    req1,
    input  client_t last,
    output logic    any,
    output client_t win
);

    assign any = req0 | req1;

    // Winner select; with both requesting, the client that was not served last wins
    always_comb begin
        win = 1'b0;
`ifdef RAMARB_FIXED_PRIO_EN
        if (req0) begin
            win = 1'b0;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
`else
        if (req0 && req1) begin
            win = ~last;
        end else if (req1) begin
            win = 1'b1;
        end else begin
            win = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/ram32b_arbiter.sv
// Two-client arbiter/sequencer for a 32 x 8 single-port synchronous RAM.
// Optional fixed-priority arbitration via RAMARB_FIXED_PRIO_EN.
module ram32b_arbiter
    import ram32b_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wr_rd,
    input  logic [DATA_W-1:0] ram_rdata
);

    state_e            state_r;
    client_t           sel_r;
    logic              cmd_we_r;
    logic [ADDR_W-1:0] cmd_addr_r;
    logic [DATA_W-1:0] cmd_wdata_r;
    logic              ram_wr_rd_r;
    logic              gnt0_r, gnt1_r;
    logic              rvalid0_r, rvalid1_r;

    logic              any_req_s;
    client_t           win_s;
    client_t           last_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    rr_arb2 u_arb (
        .req0 (req0),
        .req1 (req1),
        .last (last_s),
        .any  (any_req_s),
        .win  (win_s)
    );

`ifdef RAMARB_FIXED_PRIO_EN
    assign last_s = 1'b1;
`else
    client_t last_r;

    // Round-robin pointer: remembers the client granted on the latest CMD entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_r <= 1'b1;
        end else if ((state_r == IDLE) && any_req_s) begin
            last_r <= win_s;
        end
    end

    assign last_s = last_r;
`endif

    // Route the winning client's command fields towards the command registers
    always_comb begin
        win_we_s    = 1'b0;
        win_addr_s  = {ADDR_W{1'b0}};
        win_wdata_s = {DATA_W{1'b0}};
        if (win_s) begin
            win_we_s    = we1;
            win_addr_s  = addr1;
            win_wdata_s = wdata1;
        end else begin
            win_we_s    = we0;
            win_addr_s  = addr0;
            win_wdata_s = wdata0;
        end
    end

    // Sequencer FSM with registered strobes and RAM command
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            sel_r       <= 1'b0;
            cmd_we_r    <= 1'b0;
            cmd_addr_r  <= {ADDR_W{1'b0}};
            cmd_wdata_r <= {DATA_W{1'b0}};
            ram_wr_rd_r <= OP_RD;
            gnt0_r      <= 1'b0;
            gnt1_r      <= 1'b0;
            rvalid0_r   <= 1'b0;
            rvalid1_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                    if (any_req_s) begin
                        state_r     <= CMD;
                        sel_r       <= win_s;
                        cmd_we_r    <= win_we_s;
                        cmd_addr_r  <= win_addr_s;
                        cmd_wdata_r <= win_wdata_s;
                        ram_wr_rd_r <= win_we_s ? OP_WR : OP_RD;
                        gnt0_r      <= ~win_s;
                        gnt1_r      <= win_s;
                    end else begin
                        ram_wr_rd_r <= OP_RD;
                        gnt0_r      <= 1'b0;
                        gnt1_r      <= 1'b0;
                    end
                end
                CMD: begin
                    gnt0_r      <= 1'b0;
                    gnt1_r      <= 1'b0;
                    ram_wr_rd_r <= OP_RD;
                    if (cmd_we_r == OP_WR) begin
                        state_r <= IDLE;
                    end else begin
                        // RAM output register loads at this edge; present it next cycle
                        state_r   <= RDWAIT;
                        rvalid0_r <= ~sel_r;
                        rvalid1_r <= sel_r;
                    end
                end
                RDWAIT: begin
                    state_r   <= IDLE;
                    rvalid0_r <= 1'b0;
                    rvalid1_r <= 1'b0;
                end
                default: begin
                    state_r     <= IDLE;
                    ram_wr_rd_r <= OP_RD;
                    gnt0_r      <= 1'b0;
                    gnt1_r      <= 1'b0;
                    rvalid0_r   <= 1'b0;
                    rvalid1_r   <= 1'b0;
                end
            endcase
        end
    end

    assign gnt0      = gnt0_r;
    assign gnt1      = gnt1_r;
    assign rvalid0   = rvalid0_r;
    assign rvalid1   = rvalid1_r;
    assign ram_addr  = cmd_addr_r;
    assign ram_wdata = cmd_wdata_r;
    assign ram_wr_rd = ram_wr_rd_r;
    // RAM data_out is already a register; gate it so rdata is 0 when not valid
    assign rdata     = (rvalid0_r | rvalid1_r) ? ram_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_ram32b_arbiter.sv
// Directed self-checking bench for ram32b_arbiter with a 32 x 8 RAM model.
module tb_ram32b_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, we0, req1, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic       ram_wr_rd;
    logic [7:0] ram_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:31];

    ram32b_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .we0       (we0),
        .addr0     (addr0),
        .wdata0    (wdata0),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wr_rd (ram_wr_rd),
        .ram_rdata (ram_rdata)
    );

    // Single-port RAM model: registered read, 1 = write, cleared by reset
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
            ram_rdata <= 8'h00;
        end else if (ram_wr_rd) begin
            mem[ram_addr] <= ram_wdata;
        end else begin
            ram_rdata <= mem[ram_addr];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int c, input logic r, input logic w,
                           input logic [4:0] a, input logic [7:0] d);
        if (c == 0) begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic do_write(input int c, input logic [4:0] a, input logic [7:0] d);
        set_req(c, 1'b1, 1'b1, a, d);
        tick();
        chk("wr_gnt",       (c == 0) ? gnt0 : gnt1, 32'd1);
        chk("wr_gnt_other", (c == 0) ? gnt1 : gnt0, 32'd0);
        chk("wr_op",        ram_wr_rd, 32'd1);
        chk("wr_addr",      ram_addr, a);
        chk("wr_data",      ram_wdata, d);
        set_req(c, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("wr_gnt_off",   gnt0 | gnt1, 32'd0);
        chk("wr_op_off",    ram_wr_rd, 32'd0);
        chk("wr_mem",       mem[a], d);
    endtask

    task automatic do_read(input int c, input logic [4:0] a, input logic [7:0] exp);
        set_req(c, 1'b1, 1'b0, a, 8'd0);
        tick();
        chk("rd_gnt",    (c == 0) ? gnt0 : gnt1, 32'd1);
        chk("rd_op",     ram_wr_rd, 32'd0);
        chk("rd_addr",   ram_addr, a);
        set_req(c, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("rd_rvalid",       (c == 0) ? rvalid0 : rvalid1, 32'd1);
        chk("rd_rvalid_other", (c == 0) ? rvalid1 : rvalid0, 32'd0);
        chk("rd_gnt_off",      gnt0 | gnt1, 32'd0);
        chk("rd_rdata",        rdata, exp);
        tick();
        chk("rd_rvalid_off",   rvalid0 | rvalid1, 32'd0);
    endtask

    initial begin
        logic exp_g1;
        rst = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = 5'd0; wdata0 = 8'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = 5'd0; wdata1 = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_strobes", {gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
        chk("rst_ram",     {ram_addr, ram_wdata, ram_wr_rd}, 32'd0);
        chk("rst_rdata",   rdata, 32'd0);
        rst = 1'b1;
        tick();

        // Basic write then read by the other client
        do_write(0, 5'd3, 8'hA5);
        do_read(1, 5'd3, 8'hA5);

        // Simultaneous reads: client 0 first, no overlapping strobes
        do_write(0, 5'd1, 8'h11);
        do_write(1, 5'd2, 8'h22);
        set_req(0, 1'b1, 1'b0, 5'd1, 8'd0);
        set_req(1, 1'b1, 1'b0, 5'd2, 8'd0);
        tick();
        chk("sim_gnt0", {gnt0, gnt1}, 32'd2);
        chk("sim_addr0", ram_addr, 32'd1);
        set_req(0, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("sim_rv0", {rvalid0, rvalid1, gnt0, gnt1}, 32'd8);
        chk("sim_rdata0", rdata, 32'h11);
        tick();
        chk("sim_gap", {rvalid0, rvalid1, gnt0, gnt1}, 32'd0);
        tick();
        chk("sim_gnt1", {gnt0, gnt1}, 32'd1);
        chk("sim_addr1", ram_addr, 32'd2);
        set_req(1, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        chk("sim_rv1", {rvalid0, rvalid1, gnt0, gnt1}, 32'd4);
        chk("sim_rdata1", rdata, 32'h22);
        tick();

        // Both clients hold write requests for six grants
        set_req(0, 1'b1, 1'b1, 5'd10, 8'h50);
        set_req(1, 1'b1, 1'b1, 5'd11, 8'h61);
        for (int i = 0; i < 6; i++) begin
            tick();
`ifdef RAMARB_FIXED_PRIO_EN
            exp_g1 = 1'b0;
`else
            exp_g1 = (i % 2 == 1) ? 1'b1 : 1'b0;
`endif
            chk("alt_gnt", {gnt0, gnt1}, {30'd0, ~exp_g1, exp_g1});
            if (i == 5) begin
                set_req(0, 1'b0, 1'b0, 5'd0, 8'd0);
                set_req(1, 1'b0, 1'b0, 5'd0, 8'd0);
            end
            tick();
            chk("alt_idle", {gnt0, gnt1}, 32'd0);
        end
        chk("alt_mem10", mem[10], 32'h50);

        // Back-to-back write/read of address 31, then address 0 kept distinct
        set_req(0, 1'b1, 1'b1, 5'd31, 8'hC3);
        tick();
        chk("b2b_wr_gnt", {gnt0, ram_wr_rd, ram_addr}, {25'd0, 1'b1, 1'b1, 5'd31});
        set_req(0, 1'b1, 1'b0, 5'd31, 8'h00);
        tick();
        chk("b2b_idle", {gnt0, ram_wr_rd}, 32'd0);
        do_read(0, 5'd31, 8'hC3);
        do_write(1, 5'd0, 8'h0F);
        do_read(0, 5'd31, 8'hC3);
        do_read(1, 5'd0, 8'h0F);

        // Reset during CMD of a write aborts it
        set_req(0, 1'b1, 1'b1, 5'd7, 8'h3C);
        tick();
        chk("mid_gnt", {gnt0, ram_wr_rd}, 32'd3);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_strobes", {gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
        chk("mid_ram", {ram_addr, ram_wdata, ram_wr_rd}, 32'd0);
        chk("mid_rdata", rdata, 32'd0);
        set_req(0, 1'b0, 1'b0, 5'd0, 8'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("mid_mem7", mem[7], 32'd0);
        do_read(0, 5'd7, 8'h00);

        // Idle: no commands, no strobes
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_quiet", {gnt0, gnt1, rvalid0, rvalid1, ram_wr_rd}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
